// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SBC  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_ASR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_SHLN = 4'd13,
        OP_SHRN = 4'd14,
        OP_MUL  = 4'd15
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_R = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle combinational datapath for opcodes 0-12; ops it does not handle
// return zero and pass carry/rotate flags through unchanged.
module alu_comb_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             rin,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             rout,
    output logic             v
);

    logic [WIDTH-1:0] bx;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic             is_sub;

    // Subtraction reuses the adder with inverted B; C=1 then means no borrow.
    assign is_sub = (op == OP_SUB) || (op == OP_SBC);
    assign bx     = is_sub ? ~b : b;
    assign ci     = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    assign sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};

    always_comb begin
        res  = '0;
        cout = cin;
        rout = rin;
        v    = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                v    = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res  = {a[WIDTH-2:0], 1'b0};
                rout = a[WIDTH-1];
            end
            OP_SHR: begin
                res  = {1'b0, a[WIDTH-1:1]};
                rout = a[0];
            end
            OP_ASR: begin
                res  = {a[WIDTH-1], a[WIDTH-1:1]};
                rout = a[0];
            end
            OP_ROL: {rout, res} = {a, rin};
            OP_ROR: {res, rout} = {rin, a};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with persistent N/V/Z/R/C flags, valid/ready handshake and
// iterative variable shift and shift-add multiply.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic [4:0]       flags,
    input  logic             flags_wr,
    input  logic [4:0]       flags_wdata
);

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    localparam int CW = SAW + 1;

    state_e           state_q;
    op_e              busy_op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
    logic [WIDTH-1:0] res_q, res_hi_q;
    logic [4:0]       flags_q;
    logic             out_valid_q;

    op_e              op_i;
    logic             accept, is_shn, multi;
    logic [SAW-1:0]   k;
    logic [WIDTH-1:0] core_res;
    logic             core_cout, core_rout, core_v;

    assign op_i      = op_e'(op);
    assign k         = b[SAW-1:0];
    assign is_shn    = (op_i == OP_SHLN) || (op_i == OP_SHRN);
    assign multi     = (is_shn && (k != '0)) || (op_i == OP_MUL);
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign flags     = flags_q;

    alu_comb_core #(.WIDTH(WIDTH)) u_comb (
        .op   (op_i),
        .a    (a),
        .b    (b),
        .cin  (flags_q[FLAG_C]),
        .rin  (flags_q[FLAG_R]),
        .res  (core_res),
        .cout (core_cout),
        .rout (core_rout),
        .v    (core_v)
    );

    // One iteration of the multi-cycle work: a single-bit shift, or one
    // conditional add of the multiplicand followed by a right shift of {hi,lo}.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_bit;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        step_hi  = '0;
        step_lo  = lo_q;
        step_bit = flags_q[FLAG_R];
        case (busy_op_q)
            OP_SHLN: begin
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
                step_bit = lo_q[WIDTH-1];
            end
            OP_SHRN: begin
                step_lo  = {1'b0, lo_q[WIDTH-1:1]};
                step_bit = lo_q[0];
            end
            default: {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
        endcase
    end

    logic             load;
    logic [WIDTH-1:0] new_res, new_hi;
    logic [4:0]       fmask, fval, flag_base;

    assign flag_base = flags_wr ? flags_wdata : flags_q;

    always_comb begin
        load    = 1'b0;
        new_res = '0;
        new_hi  = '0;
        fmask   = '0;
        fval    = '0;
        if (accept && !multi) begin
            load          = 1'b1;
            new_res       = is_shn ? a : core_res;
            fmask[FLAG_Z] = 1'b1;
            fmask[FLAG_N] = 1'b1;
            fval[FLAG_Z]  = (new_res == '0);
            fval[FLAG_N]  = new_res[WIDTH-1];
            if (op_i inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC}) begin
                fmask[FLAG_C] = 1'b1;
                fmask[FLAG_V] = 1'b1;
                fval[FLAG_C]  = core_cout;
                fval[FLAG_V]  = core_v;
            end else if (op_i inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR}) begin
                fmask[FLAG_R] = 1'b1;
                fval[FLAG_R]  = core_rout;
            end
        end else if ((state_q == BUSY) && (cnt_q == CW'(1))) begin
            load          = 1'b1;
            new_res       = step_lo;
            fmask[FLAG_Z] = 1'b1;
            fmask[FLAG_N] = 1'b1;
            fval[FLAG_N]  = step_lo[WIDTH-1];
            if (busy_op_q == OP_MUL) begin
                new_hi        = step_hi;
                fval[FLAG_Z]  = ({step_hi, step_lo} == '0);
                fmask[FLAG_C] = 1'b1;
                fval[FLAG_C]  = (step_hi != '0);
            end else begin
                fval[FLAG_Z]  = (step_lo == '0);
                fmask[FLAG_R] = 1'b1;
                fval[FLAG_R]  = step_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_op_q   <= OP_ADD;
            cnt_q       <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            res_hi_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Operation-written fields override the preload for the same edge.
            flags_q <= (flag_base & ~fmask) | (fval & fmask);

            if (load) begin
                res_q       <= new_res;
                res_hi_q    <= new_hi;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept && multi) begin
                        state_q   <= BUSY;
                        busy_op_q <= op_i;
                        mcand_q   <= a;
                        hi_q      <= '0;
                        lo_q      <= is_shn ? a : b;
                        cnt_q     <= is_shn ? CW'(k) : CW'(WIDTH);
                    end
                end
                BUSY: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8) with hand-computed expectations.
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res, res_hi;
    logic [4:0] flags;
    logic       flags_wr;
    logic [4:0] flags_wdata;

    int tests  = 0;
    int failed = 0;
    int edges;
    int seen;

    alu_seq_core #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res         (res),
        .res_hi      (res_hi),
        .flags       (flags),
        .flags_wr    (flags_wr),
        .flags_wdata (flags_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one operation, returns #1 after its accept edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        out_ready = 1'b1; flags_wr = 1'b0; flags_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_res", {8'd0, res}, 16'h0000);
        check("rst_res_hi", {8'd0, res_hi}, 16'h0000);
        check("rst_flags", {11'd0, flags}, 16'h0000);

        issue(OP_ADD, 8'hF0, 8'h20);
        check("add1_valid", {15'd0, out_valid}, 16'd1);
        check("add1_res", {8'd0, res}, 16'h0010);
        check("add1_flags", {11'd0, flags}, 16'h0001);

        issue(OP_ADD, 8'h7F, 8'h01);
        check("add2_res", {8'd0, res}, 16'h0080);
        check("add2_flags", {11'd0, flags}, 16'h0018);

        issue(OP_SUB, 8'h50, 8'h50);
        check("sub_res", {8'd0, res}, 16'h0000);
        check("sub_flags", {11'd0, flags}, 16'h0005);

        flags_wr = 1'b1; flags_wdata = 5'b00010;
        @(posedge clk); #1;
        flags_wr = 1'b0;
        check("preload_flags", {11'd0, flags}, 16'h0002);

        issue(OP_ROL, 8'h81, 8'h00);
        check("rol_res", {8'd0, res}, 16'h0003);
        check("rol_flags", {11'd0, flags}, 16'h0002);

        issue(OP_ROR, 8'h02, 8'h00);
        check("ror_res", {8'd0, res}, 16'h0081);
        check("ror_flags", {11'd0, flags}, 16'h0010);

        issue(OP_SHLN, 8'h01, 8'h03);
        check("shln_busy_ready", {15'd0, in_ready}, 16'd0);
        check("shln_busy_valid", {15'd0, out_valid}, 16'd0);
        wait_result(edges);
        check("shln_latency", edges[15:0], 16'd3);
        check("shln_res", {8'd0, res}, 16'h0008);
        check("shln_flags", {11'd0, flags}, 16'h0000);

        issue(OP_SHRN, 8'h03, 8'h01);
        wait_result(edges);
        check("shrn1_latency", edges[15:0], 16'd1);
        check("shrn1_res", {8'd0, res}, 16'h0001);
        check("shrn1_flags", {11'd0, flags}, 16'h0002);

        issue(OP_SHLN, 8'h80, 8'h00);
        check("shln0_valid", {15'd0, out_valid}, 16'd1);
        check("shln0_res", {8'd0, res}, 16'h0080);
        check("shln0_flags", {11'd0, flags}, 16'h0012);

        issue(OP_MUL, 8'hFF, 8'hFF);
        wait_result(edges);
        check("mul_latency", edges[15:0], 16'd8);
        check("mul_res", {res_hi, res}, 16'hFE01);
        check("mul_flags", {11'd0, flags}, 16'h0003);

        issue(OP_MUL, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_flags", {11'd0, flags}, 16'h0000);
        check("midrst_res", {res_hi, res}, 16'h0000);
        check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_valid", seen[15:0], 16'd0);

        out_ready = 1'b0;
        issue(OP_ADD, 8'hFF, 8'h03);
        in_valid = 1'b1; op = OP_ADC; a = 8'hFF; b = 8'h00;
        check("bp_in_ready", {15'd0, in_ready}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_valid_held", {15'd0, out_valid}, 16'd1);
        check("bp_res_held", {8'd0, res}, 16'h0002);
        check("bp_flags", {11'd0, flags}, 16'h0001);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("adc_valid", {15'd0, out_valid}, 16'd1);
        check("adc_res", {8'd0, res}, 16'h0000);
        check("adc_flags", {11'd0, flags}, 16'h0005);

        flags_wr = 1'b1; flags_wdata = 5'b11110;
        issue(OP_ADC, 8'h01, 8'h01);
        flags_wr = 1'b0;
        check("wr_conflict_res", {8'd0, res}, 16'h0003);
        check("wr_conflict_flags", {11'd0, flags}, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
